// File: rtl/exp3_apresentador_sequencia_pkg.sv
// Shared definitions for the memory-sequence game: state codes,
// ROM geometry and the stored sequence contents.
package exp3_apresentador_sequencia_pkg;

    // ROM geometry shared by the presenter and the comparison datapath.
    localparam int ROM_PROF = 16;
    localparam int ROM_LARG = 4;
    localparam int ROM_END  = 4;

    // State codes, also shown on the hexa7seg debug display.
    typedef enum logic [3:0] {
        ST_INICIAL   = 4'h0,
        ST_CARREGA   = 4'h1,
        ST_MOSTRA    = 4'h2,
        ST_INTERVALO = 4'h3,
        ST_PROXIMO   = 4'h4,
        ST_FIM       = 4'hF
    } estado_t;

    // Stored sequence, indexed by ROM address.
    function automatic logic [ROM_LARG-1:0] seq_palavra(
        input logic [ROM_END-1:0] a
    );
        logic [ROM_LARG-1:0] w;
        case (a)
            4'd0:    w = 4'b0001;
            4'd1:    w = 4'b0010;
            4'd2:    w = 4'b0100;
            4'd3:    w = 4'b1000;
            4'd4:    w = 4'b0100;
            4'd5:    w = 4'b0010;
            4'd6:    w = 4'b0001;
            4'd7:    w = 4'b0001;
            4'd8:    w = 4'b0010;
            4'd9:    w = 4'b0010;
            4'd10:   w = 4'b0100;
            4'd11:   w = 4'b0100;
            4'd12:   w = 4'b1000;
            4'd13:   w = 4'b1000;
            4'd14:   w = 4'b0001;
            4'd15:   w = 4'b0100;
            default: w = 4'b0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sync_rom_16x4.sv
// 16x4 ROM with registered read, contents taken from the shared package.
// Ports: i_clk, i_rst_n (async, active-low), i_endereco, o_dado (valid one cycle later).
module sync_rom_16x4
    import exp3_apresentador_sequencia_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [ROM_END-1:0]  i_endereco,
    output logic [ROM_LARG-1:0] o_dado
);

    logic [ROM_LARG-1:0] r_dado;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dado <= '0;
        end else begin
            r_dado <= seq_palavra(i_endereco);
        end
    end

    assign o_dado = r_dado;

endmodule

// File: rtl/exp3_apresentador_sequencia.sv
// Plays the stored sequence out to the LEDs: each entry lit for TEMPO_ACESO
// cycles, then blank for TEMPO_APAGADO cycles, addresses 0..TAMANHO-1.
// Ports: clock, reset (async, active-low), iniciar (start), leds (shown word),
// mostrando (in MOSTRA), pronto (in FIM), db_endereco, db_estado (debug).
module exp3_apresentador_sequencia
    import exp3_apresentador_sequencia_pkg::*;
#(
    parameter int TEMPO_ACESO   = 50_000_000,
    parameter int TEMPO_APAGADO = 25_000_000,
    parameter int TAMANHO       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    output logic [ROM_LARG-1:0] leds,
    output logic                mostrando,
    output logic                pronto,
    output logic [ROM_END-1:0]  db_endereco,
    output logic [3:0]          db_estado
);

    localparam int TEMPO_MAX =
        (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    localparam int TW_CALC = $clog2(TEMPO_MAX);
    // A one-cycle interval still needs a one-bit timer.
    localparam int TW = (TW_CALC < 1) ? 1 : TW_CALC;

    localparam logic [TW-1:0]      LIM_ACESO   = TW'(TEMPO_ACESO - 1);
    localparam logic [TW-1:0]      LIM_APAGADO = TW'(TEMPO_APAGADO - 1);
    localparam logic [ROM_END-1:0] END_ULTIMO  = ROM_END'(TAMANHO - 1);

    estado_t             r_estado;
    logic [ROM_END-1:0]  r_endereco;
    logic [TW-1:0]       r_timer;
    logic                r_mostrando;
    logic                r_pronto;

    logic [ROM_LARG-1:0] w_rom_dado;
    logic                w_fim_aceso;
    logic                w_fim_apagado;
    logic                w_ultimo;

    sync_rom_16x4 u_rom (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_endereco (r_endereco),
        .o_dado     (w_rom_dado)
    );

    assign w_fim_aceso   = (r_timer == LIM_ACESO);
    assign w_fim_apagado = (r_timer == LIM_APAGADO);
    assign w_ultimo      = (r_endereco == END_ULTIMO);

    // Status flags are registered alongside the next state, so they
    // change on the same edge as the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado    <= ST_INICIAL;
            r_endereco  <= '0;
            r_timer     <= '0;
            r_mostrando <= 1'b0;
            r_pronto    <= 1'b0;
        end else begin
            unique case (r_estado)
                ST_INICIAL: begin
                    if (iniciar) begin
                        r_estado   <= ST_CARREGA;
                        r_endereco <= '0;
                        r_timer    <= '0;
                    end
                end
                ST_CARREGA: begin
                    // ROM sees the address now; data is valid in MOSTRA.
                    r_estado    <= ST_MOSTRA;
                    r_timer     <= '0;
                    r_mostrando <= 1'b1;
                end
                ST_MOSTRA: begin
                    if (w_fim_aceso) begin
                        r_estado    <= ST_INTERVALO;
                        r_timer     <= '0;
                        r_mostrando <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_INTERVALO: begin
                    if (w_fim_apagado) begin
                        r_timer <= '0;
                        if (w_ultimo) begin
                            r_estado <= ST_FIM;
                            r_pronto <= 1'b1;
                        end else begin
                            r_estado <= ST_PROXIMO;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_PROXIMO: begin
                    r_endereco <= r_endereco + ROM_END'(1);
                    r_estado   <= ST_CARREGA;
                end
                ST_FIM: begin
                    if (iniciar) begin
                        r_estado   <= ST_CARREGA;
                        r_endereco <= '0;
                        r_timer    <= '0;
                        r_pronto   <= 1'b0;
                    end
                end
                default: begin
                    r_estado    <= ST_INICIAL;
                    r_endereco  <= '0;
                    r_timer     <= '0;
                    r_mostrando <= 1'b0;
                    r_pronto    <= 1'b0;
                end
            endcase
        end
    end

    // Registered ROM word gated by the state register; blank elsewhere.
    assign leds        = (r_estado == ST_MOSTRA) ? w_rom_dado : '0;
    assign mostrando   = r_mostrando;
    assign pronto      = r_pronto;
    assign db_endereco = r_endereco;
    assign db_estado   = r_estado;

endmodule

// File: tb/tb_exp3_apresentador_sequencia.sv
// Directed bench for the sequence presenter (TEMPO_ACESO=4,
// TEMPO_APAGADO=2, TAMANHO=16): 8-cycle period, FIM at start+127.
module tb_exp3_apresentador_sequencia;

    localparam int TA  = 4;
    localparam int TP  = 2;
    localparam int TAM = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] leds;
    logic       mostrando;
    logic       pronto;
    logic [3:0] db_endereco;
    logic [3:0] db_estado;

    int ntests = 0;
    int nfail  = 0;

    logic [3:0] seq [16] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

    exp3_apresentador_sequencia #(
        .TEMPO_ACESO   (TA),
        .TEMPO_APAGADO (TP),
        .TAMANHO       (TAM)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .leds        (leds),
        .mostrando   (mostrando),
        .pronto      (pronto),
        .db_endereco (db_endereco),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    // Packed view: {leds, estado, endereco, mostrando, pronto}.
    function automatic logic [13:0] observado();
        return {leds, db_estado, db_endereco, mostrando, pronto};
    endfunction

    // Expected view t cycles after the start edge (t=0 is CARREGA of entry 0).
    function automatic logic [13:0] esperado(input int t);
        int         i;
        int         ph;
        logic [3:0] e;
        logic [3:0] l;
        logic       m;
        i  = t / 8;
        ph = t % 8;
        l  = 4'h0;
        m  = 1'b0;
        if (t >= 127) return {4'h0, 4'hF, 4'hF, 1'b0, 1'b1};
        case (ph)
            0:          e = 4'h1;
            1, 2, 3, 4: begin e = 4'h2; l = seq[i]; m = 1'b1; end
            5, 6:       e = 4'h3;
            default:    e = 4'h4;
        endcase
        return {l, e, 4'(i), m, 1'b0};
    endfunction

    task automatic chk(input string tag, input int t,
                       input logic [13:0] o, input logic [13:0] e);
        ntests++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start pulse, then check every cycle up to 'ate'; optional stray
    // start pulse sampled at edge 'pulso'.
    task automatic rodada(input int pulso, input int ate);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("start", 0, observado(), esperado(0));
        for (int t = 1; t <= ate; t++) begin
            if (t == pulso) iniciar = 1'b1;
            tick();
            iniciar = 1'b0;
            chk("seq", t, observado(), esperado(t));
        end
    endtask

    task automatic segura_fim();
        for (int j = 0; j < 20; j++) begin
            tick();
            chk("fim_hold", j, observado(), esperado(127));
        end
    endtask

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        tick();
        tick();
        tick();
        chk("reset", 0, observado(), 14'h0);
        reset = 1'b1;
        tick();
        chk("idle", 0, observado(), 14'h0);

        // Full run from INICIAL.
        rodada(-1, 127);
        segura_fim();

        // Restart from FIM with a stray start during MOSTRA of entry 3.
        rodada(8 * 3 + 2, 127);
        segura_fim();

        // Restart, then async reset during INTERVALO of entry 7.
        rodada(-1, 8 * 7 + 5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 0, observado(), 14'h0);
        #1;
        reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("stay_inicial", j, observado(), 14'h0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/exp3_apresentador_sequencia.md
Name: exp3_apresentador_sequencia

Overview:
Presentation side of the memory-sequence game. The existing datapath/control pair reads the stored sequence and checks the player's switches against it; this block reads the same stored sequence and plays it out to the LEDs. Each entry is shown for a timed interval, followed by a blank gap. On `iniciar` it walks the 16-entry memory from address 0 to the last address, then signals `pronto`. It sits beside the comparison circuit at top level, sharing the ROM contents definition.

Parameters:
- TEMPO_ACESO, 50_000_000, clock cycles each entry is driven on `leds`; must be >= 1.
- TEMPO_APAGADO, 25_000_000, clock cycles of blank (`leds` = 0) after each entry; must be >= 1.
- TAMANHO, 16, number of sequence entries presented; 1..16.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset).
- iniciar, input, 1, start request, level-sampled.
- leds, output, 4, currently presented memory word; 0 when blank.
- mostrando, output, 1, high while in MOSTRA.
- pronto, output, 1, high in FIM until the next start.
- db_endereco, output, 4, current ROM address.
- db_estado, output, 4, state code for the hexa7seg debug display.

Behaviour:
- One clock. Reset is asynchronous and active-low. While `reset` = 0:
  - state = INICIAL
  - address = 0, timer = 0
  - `leds` = 0, `mostrando` = 0, `pronto` = 0
- State codes (db_estado): INICIAL=0x0, CARREGA=0x1, MOSTRA=0x2, INTERVALO=0x3, PROXIMO=0x4, FIM=0xF.
- INICIAL: outputs 0. On `iniciar` = 1 at an edge, go to CARREGA with address cleared to 0.
- CARREGA: 1 cycle.
  - ROM is synchronous-read: address presented here, data valid next cycle.
  - `leds` = 0; timer cleared.
- MOSTRA: exactly TEMPO_ACESO cycles.
  - `leds` = mem[address]; `mostrando` = 1.
  - When timer = TEMPO_ACESO-1, clear timer and go to INTERVALO.
- INTERVALO: exactly TEMPO_APAGADO cycles, `leds` = 0.
  - At timer = TEMPO_APAGADO-1: if address = TAMANHO-1, go to FIM; else go to PROXIMO.
- PROXIMO: 1 cycle. Address increments by 1, then go to CARREGA.
- FIM: `pronto` = 1, `leds` = 0, address held at TAMANHO-1.
  - `iniciar` = 1 goes to CARREGA with address = 0, restarting the presentation.
- Latency:
  - `iniciar` sampled at edge k gives CARREGA at k; `leds` shows mem[0] from edge k+1.
  - Period per entry is TEMPO_ACESO+TEMPO_APAGADO+2 cycles.
  - FIM is entered at edge k + TAMANHO·(TEMPO_ACESO+TEMPO_APAGADO+2) − 1.
- `iniciar` is ignored in CARREGA, MOSTRA, INTERVALO and PROXIMO. A held `iniciar` in FIM restarts immediately.
- Timer width is ceil(log2(max(TEMPO_ACESO, TEMPO_APAGADO))) bits. The timer never wraps; it is compare-and-clear.
- Address never exceeds TAMANHO-1 and never wraps.
- Reset mid-operation: immediate return to INICIAL with all outputs 0. Presentation does not resume.
- Outputs are registered or pure decodes of the state register; no combinational path from `iniciar` to any output.

Decomposition:
- Shared package (also used by the comparison datapath) holds:
  - state codes listed above;
  - ROM depth 16 and word width 4;
  - sequence contents: 0001,0010,0100,1000,0100,0010,0001,0001,0010,0010,0100,0100,1000,1000,0001,0100.
- One natural sub-module: sync_rom_16x4 (registered-read ROM initialised from the package contents). Instantiate the same module the datapath uses, not a second copy of the table.
- FSM, address counter and timer stay in this module.

Test Plan (TEMPO_ACESO=4, TEMPO_APAGADO=2, TAMANHO=16):
1. Reset: hold `reset` = 0 for 3 cycles. Expect `leds`=0, `pronto`=0, `mostrando`=0, db_estado=0x0, db_endereco=0.
2. Start: `iniciar` = 1 for 1 cycle at edge k. Expect:
   - db_estado 0x1 at k;
   - `leds`=0001 with `mostrando`=1 for edges k+1..k+4;
   - `leds`=0 for k+5..k+6;
   - `leds`=0010 from k+9.
3. Full run: after start at edge k, expect:
   - 16 entries presented in package order;
   - FIM (`pronto`=1, db_estado=0xF, db_endereco=15) first at edge k+127;
   - `pronto` stays 1 for 20 idle cycles.
4. Ignored start: pulse `iniciar` during MOSTRA of entry 3. Expect no change in `leds`/address sequence; FIM still at k+127.
5. Reset mid-run: assert `reset` = 0 asynchronously (between edges) during INTERVALO of entry 7. Expect `leds`=0 and db_estado=0x0 immediately. After release with `iniciar`=0, the block stays in INICIAL.
6. Restart from FIM: `iniciar` = 1 while `pronto`=1. Expect:
   - `pronto`=0 and CARREGA at that edge;
   - `leds`=0001 next edge;
   - second full run identical to scenario 3.
